// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch redirect flushes, load-use interlock.
// Optional performance counters are enabled by defining PIPELINE_HAZARD_CTRL_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned REDIRECT_PENALTY = 1,
   parameter int unsigned MEM_TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_MemRead,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idex_stall,
   output logic        exmem_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_bubble,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
);

   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [15:0] wait_cnt, wait_cnt_nxt;
   logic [2:0]  redir_cnt, redir_cnt_nxt;

   logic mem_wait_req;
   logic load_use;
   logic stall_all;
   logic lu_stall;
   logic flush_if;
   logic flush_id;
   logic timeout;

   assign mem_wait_req = mem_req & ~mem_ready;
   assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= 16'd0;
         redir_cnt <= 3'd0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         redir_cnt <= redir_cnt_nxt;
      end
   end

   // Priority: memory wait > branch redirect > load-use.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      redir_cnt_nxt = redir_cnt;
      stall_all     = 1'b0;
      lu_stall      = 1'b0;
      flush_if      = 1'b0;
      flush_id      = 1'b0;
      timeout       = 1'b0;
      case (state)
         RUN: begin
            if (mem_wait_req) begin
               stall_all    = 1'b1;
               wait_cnt_nxt = 16'd0;
               state_nxt    = MEM_WAIT;
            end else if (ex_branch_taken) begin
               flush_if = 1'b1;
               flush_id = 1'b1;
               if (REDIRECT_PENALTY != 0) begin
                  redir_cnt_nxt = 3'(REDIRECT_PENALTY);
                  state_nxt     = REDIRECT;
               end
            end else if (load_use) begin
               lu_stall = 1'b1;
            end
         end
         MEM_WAIT: begin
            // EX is frozen here, so branches and load-use wait for RUN.
            if (mem_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt == 16'(MEM_TIMEOUT)) begin
               timeout   = 1'b1;
               state_nxt = RUN;
            end else begin
               stall_all    = 1'b1;
               wait_cnt_nxt = wait_cnt + 16'd1;
            end
         end
         REDIRECT: begin
            if (mem_wait_req) begin
               stall_all     = 1'b1;
               wait_cnt_nxt  = 16'd0;
               redir_cnt_nxt = 3'd0;
               state_nxt     = MEM_WAIT;
            end else begin
               flush_if = 1'b1;
               if (redir_cnt <= 3'd1) begin
                  redir_cnt_nxt = 3'd0;
                  state_nxt     = RUN;
               end else begin
                  redir_cnt_nxt = redir_cnt - 3'd1;
               end
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // A flush wins over a stall on the same register; everything is quiet in reset.
   assign pc_stall     = ~reset & (stall_all | lu_stall);
   assign ifid_stall   = ~reset & (stall_all | lu_stall) & ~flush_if;
   assign idex_stall   = ~reset & stall_all & ~(flush_id | lu_stall);
   assign exmem_stall  = ~reset & stall_all;
   assign ifid_flush   = ~reset & flush_if;
   assign idex_flush   = ~reset & (flush_id | lu_stall);
   assign memwb_bubble = ~reset & stall_all;
   assign mem_timeout  = ~reset & timeout;

`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (pc_stall)   stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign stall_cycles = reset ? 32'd0 : stall_cnt;
   assign flush_cycles = reset ? 32'd0 : flush_cnt;
`else
   assign stall_cycles = 32'd0;
   assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REDIRECT_PENALTY=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REDIRECT_PENALTY = 2;
   localparam int unsigned MEM_TIMEOUT      = 4;

   // Output vector bit order: pc_stall, ifid_stall, idex_stall, exmem_stall,
   // ifid_flush, idex_flush, memwb_bubble, mem_timeout.
   localparam logic [7:0] NONE = 8'b0000_0000;
   localparam logic [7:0] LU   = 8'b1100_0100;
   localparam logic [7:0] MW   = 8'b1111_0010;
   localparam logic [7:0] BR   = 8'b0000_1100;
   localparam logic [7:0] RD   = 8'b0000_1000;
   localparam logic [7:0] TO   = 8'b0000_0001;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken, mem_req, mem_ready;
   logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout;
   logic [31:0] stall_cycles, flush_cycles;
   logic [7:0]  outs;

   int n_cmp;
   int n_err;

   pipeline_hazard_ctrl #(
      .REDIRECT_PENALTY(REDIRECT_PENALTY),
      .MEM_TIMEOUT     (MEM_TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd          (ex_rd),
      .ex_MemRead     (ex_MemRead),
      .ex_branch_taken(ex_branch_taken),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_stall       (pc_stall),
      .ifid_stall     (ifid_stall),
      .idex_stall     (idex_stall),
      .exmem_stall    (exmem_stall),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .memwb_bubble   (memwb_bubble),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .flush_cycles   (flush_cycles)
   );

   assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                  ifid_flush, idex_flush, memwb_bubble, mem_timeout};

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic bt, input logic mreq, input logic mrdy);
      id_rs1          = rs1;
      id_rs2          = rs2;
      id_uses_rs1     = u1;
      id_uses_rs2     = u2;
      ex_rd           = rd;
      ex_MemRead      = mr;
      ex_branch_taken = bt;
      mem_req         = mreq;
      mem_ready       = mrdy;
   endtask

   task automatic idle();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Check outputs on the falling edge, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [7:0] exp);
      @(negedge clk);
      check(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc("reset_outputs", NONE);
      reset = 1'b0;
      idle();
      cyc("idle", NONE);

      // Load-use variants
      drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_rs1", LU);
      idle();
      cyc("lu_rs1_after", NONE);
      drv(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_rs2", LU);
      drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_rd_zero", NONE);
      drv(5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_unused_src", NONE);
      drv(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("lu_not_load", NONE);

      // Memory wait: ready low for 3 cycles, then high
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("mw_c1", MW);
      cyc("mw_c2", MW);
      cyc("mw_c3", MW);
      mem_ready = 1'b1;
      cyc("mw_ready", NONE);
      idle();
      cyc("mw_done", NONE);

      // Load-use is deferred while memory waits
      drv(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("mw_lu_c1", MW);
      cyc("mw_lu_c2", MW);
      mem_ready = 1'b1;
      cyc("mw_lu_ready", NONE);
      mem_req = 1'b0;
      mem_ready = 1'b0;
      cyc("mw_lu_deferred", LU);
      idle();
      cyc("mw_lu_done", NONE);

      // Branch with redirect penalty 2
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("br_taken", BR);
      idle();
      cyc("br_redir1", RD);
      cyc("br_redir2", RD);
      cyc("br_done", NONE);

      // Branch and memory wait together: memory wins, branch follows
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("cf_c1", MW);
      cyc("cf_c2", MW);
      mem_ready = 1'b1;
      cyc("cf_ready", NONE);
      mem_req = 1'b0;
      mem_ready = 1'b0;
      cyc("cf_branch", BR);
      idle();
      cyc("cf_redir1", RD);
      cyc("cf_redir2", RD);
      cyc("cf_done", NONE);

      // Memory wait arriving in REDIRECT discards the remaining flushes
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rmw_branch", BR);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rmw_c1", MW);
      cyc("rmw_c2", MW);
      mem_ready = 1'b1;
      cyc("rmw_ready", NONE);
      idle();
      cyc("rmw_no_redirect", NONE);

      // Timeout after MEM_TIMEOUT wait-state cycles
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("to_run", MW);
      for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), MW);
      cyc("to_pulse", TO);
      idle();
      @(negedge clk);
      check("to_state_run", 32'(dut.state), 32'd0);
      cyc("to_after", NONE);

      // Reset in the middle of a memory wait
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rst_mw_c1", MW);
      cyc("rst_mw_c2", MW);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mw_stall_cnt", stall_cycles, 32'd0);
      cyc("rst_mw_outputs", NONE);
      reset = 1'b0;
      idle();
      @(negedge clk);
      check("rst_mw_stall_cnt_after", stall_cycles, 32'd0);
      check("rst_mw_flush_cnt_after", flush_cycles, 32'd0);
      cyc("rst_mw_run", NONE);

      // Reset in the middle of REDIRECT
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rst_rd_branch", BR);
      reset = 1'b1;
      idle();
      cyc("rst_rd_outputs", NONE);
      reset = 1'b0;
      cyc("rst_rd_run", NONE);

      // Performance counters from a clean reset
      drv(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("pc_lu", LU);
      idle();
      @(negedge clk);
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
      check("perf_stall_1", stall_cycles, 32'd1);
`else
      check("perf_stall_off", stall_cycles, 32'd0);
`endif
      cyc("pc_idle", NONE);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("pc_branch", BR);
      idle();
      cyc("pc_redir1", RD);
      cyc("pc_redir2", RD);
      @(negedge clk);
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
      check("perf_flush_3", flush_cycles, 32'd3);
      check("perf_stall_still_1", stall_cycles, 32'd1);
`else
      check("perf_flush_off", flush_cycles, 32'd0);
      check("perf_stall_still_off", stall_cycles, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
